mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequential arbiter that shares one single-ported memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage RV32I pipeline. It holds at most one outstanding transaction, sequences it over a fixed memory latency, returns read data to the owner, and drives per-stage stall signals to the pipeline. Data accesses win by default; a starvation guard forces fetch through after repeated losses.

## Interface
- MEM_LATENCY, 2: cycles a transaction occupies the memory port (≥1)
- STARVE_LIMIT, 4: consecutive fetch losses before fetch is forced to win; 0 disables the guard
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch requests a read; held until if_done
- if_addr  in  32  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_done  out  1  one-cycle pulse: fetch read complete
- if_rdata  out  32  fetch read data, valid while if_done
- dm_req  in  1  data stage request; held until dm_done
- dm_addr  in  32  data address
- dm_we  in  1  1 = store, 0 = load
- dm_wdata  in  32  store data
- dm_size  in  2  access size (0 byte, 1 half, 2 word)
- dm_gnt  out  1  one-cycle pulse: data request accepted
- dm_done  out  1  one-cycle pulse: load or store complete
- dm_rdata  out  32  load data, valid while dm_done
- mem_valid  out  1  transaction in progress on the memory port
- mem_address  out  32  latched transaction address
- mem_read_write  out  1  1 = write
- mem_data_in  out  32  latched store data
- mem_access_size  out  2  latched size; fetch always 2
- mem_data_out  in  32  memory read data
- stall_f  out  1  if_req & ~if_done
- stall_m  out  1  dm_req & ~dm_done

## Operation
- States: IDLE, BUSY_IF, BUSY_DM.
- IDLE, neither req: stay. One req: go to that BUSY state. Both: winner per priority below.
- Priority: dm wins unless STARVE_LIMIT≠0 and starve_cnt == STARVE_LIMIT, then fetch wins.
- starve_cnt: +1 when both requested in IDLE and dm won; cleared when fetch wins; saturates at STARVE_LIMIT.
- On accept edge: latch address, we (0 for fetch), wdata, size (2 for fetch); load lat_cnt = MEM_LATENCY; assert owner's gnt next cycle.
- BUSY_x: mem_valid=1, mem_* from latches; lat_cnt decrements each cycle. At the edge where lat_cnt==1: capture mem_data_out into owner's rdata register, pulse owner's done, go to IDLE.
- Stores: dm_done pulses identically; dm_rdata holds the captured value and is don't-care to the pipeline.
- Requests are not re-checked during BUSY; a req dropped mid-transaction does not abort it.
- Requester must deassert req in its done cycle; a req still high then is treated as a new request.
- rdata registers hold their value until the next completion for the same owner.

## Timing
- Reset (async, low): state IDLE, lat_cnt 0, starve_cnt 0, all latches 0; every output 0 (stall_f/stall_m follow inputs combinationally, so 0 only if req low). Reset mid-transaction aborts it; no done pulse follows.
- Request high in cycle N-1 and accepted at edge N: gnt and mem_valid high in cycle N; mem_valid high cycles N..N+MEM_LATENCY-1; done and rdata valid in cycle N+MEM_LATENCY (state IDLE).
- The IDLE done cycle samples requests; the next accept is at the edge ending it. Throughput: one transaction per MEM_LATENCY+1 cycles.
- Losing requester sees no gnt and keeps stall high; it is accepted in the done cycle of the winner's transaction.
- stall_f/stall_m combinational; all other outputs registered.

## Test plan
- MEM_LATENCY=2, fetch read 0x01000000, memory returns 0x00500093 -> if_gnt cycle N, mem_valid N..N+1, if_done and if_rdata=0x00500093 cycle N+2, stall_f high until N+2.
- if_req and dm_req (load 0x01000100) together -> dm wins first; fetch accepted at edge ending dm_done cycle; if_done 3 cycles after dm_done.
- STARVE_LIMIT=4, both held continuously with dm re-requesting after each done -> 4 dm transactions, then fetch wins; starve_cnt clears to 0.
- Store dm_we=1, addr 0x01000200, wdata 0xDEADBEEF, size 0 -> mem_read_write=1, mem_data_in=0xDEADBEEF, mem_access_size=0 for 2 cycles, dm_done pulse, no if_* activity.
- Reset asserted mid BUSY_DM -> all outputs 0 immediately, no dm_done; after release, held dm_req re-accepted from IDLE.
- STARVE_LIMIT=0, both requesting for 20 cycles -> fetch never granted, stall_f high throughout.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported memory between the fetch stage (instruction reads)
// and the memory stage (data loads/stores) of the 5-stage RV32I pipeline.
// At most one transaction is outstanding. It occupies the memory port for
// MEM_LATENCY cycles, and its read data is returned to the owner with a done
// pulse. Data accesses win contention by default. After STARVE_LIMIT
// consecutive fetch losses, fetch is forced through. STARVE_LIMIT = 0
// disables this guard.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   if_req/if_addr        fetch read request (held until if_done)
//   if_gnt/if_done        one-cycle pulses: fetch accepted / fetch complete
//   if_rdata              fetch read data, valid while if_done
//   dm_req/addr/we/wdata/size  data request (held until dm_done)
//   dm_gnt/dm_done        one-cycle pulses: data accepted / data complete
//   dm_rdata              load data, valid while dm_done
//   mem_valid, mem_address, mem_read_write, mem_data_in, mem_access_size
//                         memory port, driven from the transaction latches
//   mem_data_out          memory read data
//   stall_f, stall_m      per-stage stalls (request pending and not done)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_done,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic [31:0] dm_addr,
    input  logic        dm_we,
    input  logic [31:0] dm_wdata,
    input  logic [1:0]  dm_size,
    output logic        dm_gnt,
    output logic        dm_done,
    output logic [31:0] dm_rdata,
    output logic        mem_valid,
    output logic [31:0] mem_address,
    output logic        mem_read_write,
    output logic [31:0] mem_data_in,
    output logic [1:0]  mem_access_size,
    input  logic [31:0] mem_data_out,
    output logic        stall_f,
    output logic        stall_m
);

    localparam int LAT_W = $clog2(MEM_LATENCY + 1);
    localparam int STV_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t             state_reg;
    logic [LAT_W-1:0]   lat_cnt_reg;
    logic [STV_W-1:0]   starve_cnt_reg;
    logic [31:0]        addr_reg;
    logic               we_reg;
    logic [31:0]        wdata_reg;
    logic [1:0]         size_reg;
    logic               mem_valid_reg;
    logic               if_gnt_reg;
    logic               dm_gnt_reg;
    logic               if_done_reg;
    logic               dm_done_reg;
    logic [31:0]        if_rdata_reg;
    logic [31:0]        dm_rdata_reg;

    // Fetch takes priority only once it has lost STARVE_LIMIT times in a row.
    logic fetch_priority;
    logic starve_at_limit;

    assign starve_at_limit = (starve_cnt_reg == STV_W'(STARVE_LIMIT));
    assign fetch_priority  = (STARVE_LIMIT != 0) && starve_at_limit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg      <= IDLE;
            lat_cnt_reg    <= '0;
            starve_cnt_reg <= '0;
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            wdata_reg      <= '0;
            size_reg       <= '0;
            mem_valid_reg  <= 1'b0;
            if_gnt_reg     <= 1'b0;
            dm_gnt_reg     <= 1'b0;
            if_done_reg    <= 1'b0;
            dm_done_reg    <= 1'b0;
            if_rdata_reg   <= '0;
            dm_rdata_reg   <= '0;
        end else begin
            // Grant and done are single-cycle pulses.
            if_gnt_reg  <= 1'b0;
            dm_gnt_reg  <= 1'b0;
            if_done_reg <= 1'b0;
            dm_done_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (dm_req && !(if_req && fetch_priority)) begin
                        state_reg     <= BUSY_DM;
                        lat_cnt_reg   <= LAT_W'(MEM_LATENCY);
                        addr_reg      <= dm_addr;
                        we_reg        <= dm_we;
                        wdata_reg     <= dm_wdata;
                        size_reg      <= dm_size;
                        mem_valid_reg <= 1'b1;
                        dm_gnt_reg    <= 1'b1;
                        // A fetch that lost the contention counts towards
                        // starvation; saturate at the limit.
                        if (if_req && !starve_at_limit) begin
                            starve_cnt_reg <= starve_cnt_reg + 1'b1;
                        end
                    end else if (if_req) begin
                        state_reg      <= BUSY_IF;
                        lat_cnt_reg    <= LAT_W'(MEM_LATENCY);
                        addr_reg       <= if_addr;
                        we_reg         <= 1'b0;
                        wdata_reg      <= '0;
                        size_reg       <= 2'd2;
                        mem_valid_reg  <= 1'b1;
                        if_gnt_reg     <= 1'b1;
                        starve_cnt_reg <= '0;
                    end
                end

                BUSY_IF, BUSY_DM: begin
                    // Requests are ignored here; the transaction always runs
                    // to completion once accepted.
                    if (lat_cnt_reg == LAT_W'(1)) begin
                        state_reg     <= IDLE;
                        lat_cnt_reg   <= '0;
                        mem_valid_reg <= 1'b0;
                        if (state_reg == BUSY_IF) begin
                            if_rdata_reg <= mem_data_out;
                            if_done_reg  <= 1'b1;
                        end else begin
                            dm_rdata_reg <= mem_data_out;
                            dm_done_reg  <= 1'b1;
                        end
                    end else begin
                        lat_cnt_reg <= lat_cnt_reg - 1'b1;
                    end
                end

                default: begin
                    state_reg     <= IDLE;
                    lat_cnt_reg   <= '0;
                    mem_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt          = if_gnt_reg;
    assign if_done         = if_done_reg;
    assign if_rdata        = if_rdata_reg;
    assign dm_gnt          = dm_gnt_reg;
    assign dm_done         = dm_done_reg;
    assign dm_rdata        = dm_rdata_reg;
    assign mem_valid       = mem_valid_reg;
    assign mem_address     = addr_reg;
    assign mem_read_write  = we_reg;
    assign mem_data_in     = wdata_reg;
    assign mem_access_size = size_reg;

    // The pipeline stalls from the request cycle up to, but not including,
    // the done cycle.
    assign stall_f = if_req & ~if_done_reg;
    assign stall_m = dm_req & ~dm_done_reg;

endmodule
